// File: rtl/pair_sum_pkg.sv
// pair_sum_pkg: shared width default and FSM state encodings for the pair-sum solver
package pair_sum_pkg;
    localparam int W_DEF = 8;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADD1  = 3'd1;
    localparam logic [2:0] S_ADD2  = 3'd2;
    localparam logic [2:0] S_SUB_A = 3'd3;
    localparam logic [2:0] S_SUB_B = 3'd4;
    localparam logic [2:0] S_SUB_C = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ADD1  = S_ADD1,
        ADD2  = S_ADD2,
        SUB_A = S_SUB_A,
        SUB_B = S_SUB_B,
        SUB_C = S_SUB_C,
        DONE  = S_DONE
    } state_t;
endpackage

// File: rtl/pair_sum_solver_if.sv
// pair_sum_solver_if: input sum-triple and output operand handshake bundle
interface pair_sum_solver_if import pair_sum_pkg::*; #(parameter int W = W_DEF);
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sum_ab;
    logic [W:0]   sum_ac;
    logic [W:0]   sum_bc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] data_c;
    logic         err;
    modport master (
        output in_valid, sum_ab, sum_ac, sum_bc, out_ready,
        input  in_ready, out_valid, data_a, data_b, data_c, err
    );
    modport slave (
        input  in_valid, sum_ab, sum_ac, sum_bc, out_ready,
        output in_ready, out_valid, data_a, data_b, data_c, err
    );
endinterface

// File: rtl/pair_sum_alu.sv
// pair_sum_alu: shared W+3-bit add/sub with a state-selected operand mux and range flags
module pair_sum_alu import pair_sum_pkg::*; #(parameter int W = W_DEF) (
    input  state_t       state,
    input  logic [W+2:0] acc,
    input  logic [W:0]   sum_ab,
    input  logic [W:0]   sum_ac,
    input  logic [W:0]   sum_bc,
    output logic [W+2:0] res,
    output logic         neg,
    output logic         over
);
    logic [W+2:0] half, op_x, op_y;
    logic         sub;
    // ADD1/ADD2 build the total; SUB_* subtract one sum from half the total
    always_comb begin
        half = acc >> 1;
        sub  = state == SUB_A || state == SUB_B || state == SUB_C;
        op_x = state == ADD1 ? {2'b00, sum_ab} : state == ADD2 ? acc : half;
        op_y = state == ADD1  ? {2'b00, sum_ac} :
               state == SUB_B ? {2'b00, sum_ac} :
               state == SUB_C ? {2'b00, sum_ab} : {2'b00, sum_bc};
        res  = sub ? op_x - op_y : op_x + op_y;
        neg  = res[W+2];
        over = !res[W+2] && |res[W+1:W];
    end
endmodule

// File: rtl/pair_sum_solver.sv
// pair_sum_solver: recovers a, b, c from (a+b, a+c, b+c) over six sequenced steps
module pair_sum_solver import pair_sum_pkg::*; #(parameter int W = W_DEF) (
    input  logic              clk,
    input  logic              rst,
    pair_sum_solver_if.slave  bus
);
    state_t       state;
    logic [W:0]   cap_ab, cap_ac, cap_bc;
    logic [W+2:0] acc, res;
    logic [W-1:0] a_t, b_t, data_a, data_b, data_c;
    logic         a_bad, b_bad, neg, over, bad, out_valid, err;

    pair_sum_alu #(.W(W)) alu (
        .state  (state),
        .acc    (acc),
        .sum_ab (cap_ab),
        .sum_ac (cap_ac),
        .sum_bc (cap_bc),
        .res    (res),
        .neg    (neg),
        .over   (over)
    );

    assign bad           = acc[0] | a_bad | b_bad | neg | over;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = out_valid;
    assign bus.err       = err;
    assign bus.data_a    = data_a;
    assign bus.data_b    = data_b;
    assign bus.data_c    = data_c;

    // Sequencer: capture, accumulate total, derive each operand, then hold until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_ab    <= '0;
            cap_ac    <= '0;
            cap_bc    <= '0;
            acc       <= '0;
            a_t       <= '0;
            b_t       <= '0;
            a_bad     <= 1'b0;
            b_bad     <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            data_a    <= '0;
            data_b    <= '0;
            data_c    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    cap_ab <= bus.sum_ab;
                    cap_ac <= bus.sum_ac;
                    cap_bc <= bus.sum_bc;
                    state  <= ADD1;
                end
                ADD1: begin
                    acc   <= res;
                    state <= ADD2;
                end
                ADD2: begin
                    acc   <= res;
                    state <= SUB_A;
                end
                SUB_A: begin
                    a_t   <= res[W-1:0];
                    a_bad <= neg | over;
                    state <= SUB_B;
                end
                SUB_B: begin
                    b_t   <= res[W-1:0];
                    b_bad <= neg | over;
                    state <= SUB_C;
                end
                SUB_C: begin
                    err       <= bad;
                    data_a    <= bad ? '0 : a_t;
                    data_b    <= bad ? '0 : b_t;
                    data_c    <= bad ? '0 : res[W-1:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pair_sum_solver.sv
// tb_pair_sum_solver: randomized check of the pair-sum solver against an arithmetic model
module tb_pair_sum_solver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pair_sum_solver_if #(.W(8)) bus ();
    pair_sum_solver #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // a = (total/2) - (b+c) etc.; any odd total or out-of-range operand is an error
    function automatic void model(input int ab, input int ac, input int bc,
                                  output int a, output int b, output int c, output int e);
        int t;
        t = ab + ac + bc;
        e = t % 2;
        a = t / 2 - bc;
        b = t / 2 - ac;
        c = t / 2 - ab;
        if (a < 0 || b < 0 || c < 0 || a > 255 || b > 255 || c > 255) e = 1;
        if (e != 0) begin
            a = 0;
            b = 0;
            c = 0;
        end
    endfunction

    task automatic run_txn(input int ab, input int ac, input int bc, input int hold);
        int ea, eb, ec, ee, cnt;
        model(ab, ac, bc, ea, eb, ec, ee);
        @(negedge clk);
        check("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.sum_ab = 9'(ab);
        bus.sum_ac = 9'(ac);
        bus.sum_bc = 9'(bc);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.sum_ab = 9'($urandom);
        bus.sum_ac = 9'($urandom);
        bus.sum_bc = 9'($urandom);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid || cnt > 20) break;
            cnt++;
            check("busy_ready", bus.in_ready, 0);
            bus.in_valid = 1'($urandom);
            bus.out_ready = 1'($urandom);
            bus.sum_ab = 9'($urandom);
            bus.sum_ac = 9'($urandom);
            bus.sum_bc = 9'($urandom);
        end
        check("latency", cnt, 5);
        if (!bus.out_valid) return;
        bus.in_valid = 1'b0;
        bus.out_ready = (hold == 0);
        check("err", bus.err, ee);
        check("data_a", bus.data_a, ea);
        check("data_b", bus.data_b, eb);
        check("data_c", bus.data_c, ec);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            check("hold_valid", bus.out_valid, 1);
            check("hold_ready", bus.in_ready, 0);
            check("hold_data", {bus.err, bus.data_a, bus.data_b, bus.data_c},
                  {7'd0, 1'(ee), 8'(ea), 8'(eb), 8'(ec)});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", bus.out_valid, 0);
        check("post_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int a, b, c;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_ab = '0;
        bus.sum_ac = '0;
        bus.sum_bc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_out", {bus.err, bus.data_a, bus.data_b, bus.data_c}, 0);
        rst = 1'b0;

        run_txn(8, 10, 12, 0);
        run_txn(510, 510, 510, 0);
        run_txn(0, 0, 0, 1);
        run_txn(8, 10, 13, 0);
        run_txn(2, 2, 100, 2);
        run_txn(8, 10, 12, 10);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sum_ab = 9'd100;
        bus.sum_ac = 9'd120;
        bus.sum_bc = 9'd140;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_ready", bus.in_ready, 1);
        check("mid_rst_out", {bus.err, bus.data_a, bus.data_b, bus.data_c}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(20, 30, 40, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) != 0) begin
                a = $urandom_range(255);
                b = $urandom_range(255);
                c = $urandom_range(255);
                run_txn(a + b, a + c, b + c, $urandom_range(3));
            end else begin
                run_txn($urandom_range(511), $urandom_range(511), $urandom_range(511),
                        $urandom_range(3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
